utlb_translate: RTL and testbench
=================================

# utlb_translate

Address-translation front stage for one memory port (fetch or data). It owns a 4-entry fully-associative micro-TLB and translates unmapped kseg0/kseg1 addresses directly. On a micro-TLB miss it drives the main TLB lookup port for one cycle, consumes the `tlb_result_t` returned combinationally, refills itself, and responds. It sits between the pipeline's address-generation stage and the cache request logic.

## Interface
- `UTLB_ENTRIES`, default 4: micro-TLB entries; power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  translation request.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_vaddr`  in  32  virtual address.
- `req_store`  in  1  access is a store.
- `asid`  in  8  current ASID (EntryHi.ASID).
- `flush`  in  1  invalidates all micro-TLB entries (TLBWI/TLBWR/TLBR issued).
- `lookup_vaddr`  out  32  address presented to the main TLB lookup.
- `lookup_asid`  out  8  ASID presented to the main TLB lookup.
- `lookup_result`  in  `tlb_result_t`  combinational main-TLB result; uses `miss`, `valid`, `dirty`, `cache_flag`[2:0], `phy_addr`[31:0].
- `resp_valid`  out  1  single-cycle response strobe; no backpressure.
- `resp_paddr`  out  32  physical address.
- `resp_uncached`  out  1  access is uncached.
- `resp_exc`  out  2  0 none, 1 TLB refill, 2 TLB invalid, 3 TLB modified.

## Operation
- Request capture: on an accepted request, register `req_vaddr`, `req_store` and `asid` into `q_vaddr`, `q_store` and `q_asid`.
- FSM states: IDLE, CHECK, LOOKUP.
- IDLE: `req_ready`=1. An accepted request moves the FSM to CHECK.
- CHECK: classify `q_vaddr`.
  - Unmapped, `q_vaddr[31:30]`==2'b10: `resp_paddr`={3'b0, q_vaddr[28:0]}. `resp_uncached`=`q_vaddr[29]` (kseg1 uncached, kseg0 cached). `resp_exc`=0. The micro-TLB is not consulted.
  - Mapped, and micro-TLB hit: an entry with valid=1 and `vpn`==`q_vaddr[31:12]`. `resp_paddr`={pfn, q_vaddr[11:0]}; `resp_uncached`=(cache_flag != 3'd3).
  - Mapped hit with `q_store`=1 and stored dirty=0: treat as a miss and go to LOOKUP, so the main TLB reports the modified exception.
  - Hit or unmapped: assert `resp_valid`. `req_ready`=1, so a back-to-back accept returns to CHECK, otherwise go to IDLE.
  - Miss: `req_ready`=0, go to LOOKUP.
- LOOKUP: `resp_valid`=1, `req_ready`=0, then return to IDLE.
  - `lookup_result.miss` → `resp_exc`=1.
  - else `!valid` → `resp_exc`=2.
  - else `q_store & !dirty` → `resp_exc`=3.
  - else `resp_exc`=0.
  - `resp_paddr`=`lookup_result.phy_addr`; `resp_uncached`=(cache_flag != 3).
- Refill: at the end of LOOKUP, write an entry only when miss=0 and valid=1.
  - If the same vpn is already present, overwrite that entry.
  - Otherwise write the entry at the 2-bit round-robin victim pointer and increment the pointer (mod `UTLB_ENTRIES`).
  - Entry contents: vpn=`q_vaddr[31:12]`, pfn=`phy_addr[31:12]`, dirty, cache_flag.
- `lookup_vaddr`=`q_vaddr` and `lookup_asid`=`q_asid` at all times.
- Flush sources: `flush`=1, or `asid` differing from the internally registered `last_asid`. Either clears all entry valid bits at the clock edge.
- Flush and refill in the same cycle: flush wins and no entry is written.
- A flush never cancels an in-flight request; its response is still produced from the current state.
- At most one micro-TLB entry may ever match a vpn. Hit selection uses a one-hot OR.

## Timing
- Reset: all entries invalid, victim pointer 0, FSM in IDLE, `last_asid`=0.
- Outputs during `rst`=1: `resp_valid`=0, `resp_paddr`=0, `resp_uncached`=0, `resp_exc`=0, `req_ready`=0.
- `req_ready`=1 in the first cycle after `rst` deasserts.
- Accept in cycle T:
  - unmapped or micro-TLB hit → `resp_valid` in T+1;
  - miss → `resp_valid` in T+2.
- Throughput: one translation per cycle on hits; a miss costs one extra stall cycle.
- Response outputs are valid only while `resp_valid`=1 and are combinational from state.
- `rst` asserted mid-LOOKUP: no response and no refill; the FSM returns to IDLE.
- The main-TLB path is combinational within the LOOKUP cycle.

## Test plan
- Reset, then request `vaddr`=0x8000_1234, load → `resp_valid` at T+1, `resp_paddr`=0x0000_1234, `resp_uncached`=0, `resp_exc`=0. Request 0xA000_0010 → paddr 0x0000_0010, `resp_uncached`=1.
- Request 0x0040_0ABC, lookup returns miss=0, valid=1, dirty=1, cache=3, phy_addr=0x1234_5ABC → response at T+2 with that paddr. The same vpn again → hit at T+1 with no LOOKUP cycle.
- Lookup with miss=1 → `resp_exc`=1 and no refill. Lookup with valid=0 → `resp_exc`=2. A store to an entry with dirty=0 (cached or uncached) → LOOKUP, `resp_exc`=3.
- Refill 5 distinct vpns → the fifth evicts the first (victim pointer wrapped). Re-requesting the first vpn → miss.
- Fill an entry; pulse `flush` in the same cycle as a new refill → the next requests to both vpns miss. Change `asid` 0x01→0x02 → the previously cached vpn misses.
- Back-to-back hits with `req_valid` held high for 8 cycles → 8 `resp_valid` pulses on consecutive cycles. Assert `rst` during LOOKUP → no `resp_valid`, and `req_ready`=1 on the cycle after release.

Source files
------------

// File: rtl/utlb_translate.sv
// rtl/utlb_translate.sv - micro-TLB front stage translating one memory port's virtual addresses
package utlb_pkg;
  typedef struct packed {
    logic        miss;
    logic        valid;
    logic        dirty;
    logic [2:0]  cache_flag;
    logic [31:0] phy_addr;
  } tlb_result_t;
endpackage

module utlb_translate
  import utlb_pkg::*;
#(
  parameter int UTLB_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_vaddr,
  input  logic        req_store,
  input  logic [7:0]  asid,
  input  logic        flush,
  output logic [31:0] lookup_vaddr,
  output logic [7:0]  lookup_asid,
  input  tlb_result_t lookup_result,
  output logic        resp_valid,
  output logic [31:0] resp_paddr,
  output logic        resp_uncached,
  output logic [1:0]  resp_exc
);
  localparam int IW = $clog2(UTLB_ENTRIES);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_LOOKUP} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             vaddr_q, vaddr_d;
  logic                    store_q, store_d;
  logic [7:0]              asid_q, asid_d;
  logic [7:0]              last_asid_q, last_asid_d;
  logic [IW-1:0]           victim_q, victim_d;
  logic [UTLB_ENTRIES-1:0] valid_q, valid_d;
  logic [UTLB_ENTRIES-1:0] dirty_q, dirty_d;
  logic [19:0]             vpn_q [UTLB_ENTRIES];
  logic [19:0]             vpn_d [UTLB_ENTRIES];
  logic [19:0]             pfn_q [UTLB_ENTRIES];
  logic [19:0]             pfn_d [UTLB_ENTRIES];
  logic [2:0]              cache_q [UTLB_ENTRIES];
  logic [2:0]              cache_d [UTLB_ENTRIES];

  logic [UTLB_ENTRIES-1:0] match;
  logic [19:0]             hit_pfn;
  logic [2:0]              hit_cache;
  logic                    hit_dirty;
  logic                    any_match, unmapped, hit_ok, flush_all, accept, refill;

  // Entries never alias a vpn, so the hit fields are a plain one-hot OR.
  always_comb begin
    match     = '0;
    hit_pfn   = '0;
    hit_cache = '0;
    hit_dirty = 1'b0;
    for (int i = 0; i < UTLB_ENTRIES; i++) begin
      match[i]  = valid_q[i] && (vpn_q[i] == vaddr_q[31:12]);
      hit_pfn   = hit_pfn | ({20{match[i]}} & pfn_q[i]);
      hit_cache = hit_cache | ({3{match[i]}} & cache_q[i]);
      hit_dirty = hit_dirty | (match[i] & dirty_q[i]);
    end
  end

  assign any_match    = |match;
  assign unmapped     = (vaddr_q[31:30] == 2'b10);
  // A store to a clean entry goes to the main TLB so it raises the modified exception.
  assign hit_ok       = unmapped || (any_match && !(store_q && !hit_dirty));
  assign flush_all    = flush || (asid != last_asid_q);
  assign lookup_vaddr = vaddr_q;
  assign lookup_asid  = asid_q;
  assign accept       = req_valid && req_ready;

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_paddr    = '0;
    resp_uncached = 1'b0;
    resp_exc      = 2'd0;
    refill        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (hit_ok) begin
          resp_valid = 1'b1;
          req_ready  = 1'b1;
          if (unmapped) begin
            resp_paddr    = {3'b000, vaddr_q[28:0]};
            resp_uncached = vaddr_q[29];
          end else begin
            resp_paddr    = {hit_pfn, vaddr_q[11:0]};
            resp_uncached = (hit_cache != 3'd3);
          end
          state_d = req_valid ? S_CHECK : S_IDLE;
        end else begin
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        resp_valid    = 1'b1;
        resp_paddr    = lookup_result.phy_addr;
        resp_uncached = (lookup_result.cache_flag != 3'd3);
        if (lookup_result.miss)                        resp_exc = 2'd1;
        else if (!lookup_result.valid)                 resp_exc = 2'd2;
        else if (store_q && !lookup_result.dirty)      resp_exc = 2'd3;
        else                                           resp_exc = 2'd0;
        refill  = !lookup_result.miss && lookup_result.valid;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_paddr    = '0;
      resp_uncached = 1'b0;
      resp_exc      = 2'd0;
      refill        = 1'b0;
    end
  end

  always_comb begin
    vaddr_d     = vaddr_q;
    store_d     = store_q;
    asid_d      = asid_q;
    last_asid_d = asid;
    victim_d    = victim_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    vpn_d       = vpn_q;
    pfn_d       = pfn_q;
    cache_d     = cache_q;
    if (accept) begin
      vaddr_d = req_vaddr;
      store_d = req_store;
      asid_d  = asid;
    end
    // Flush beats a same-cycle refill.
    if (flush_all) begin
      valid_d = '0;
    end else if (refill) begin
      for (int i = 0; i < UTLB_ENTRIES; i++) begin
        if (any_match ? match[i] : (victim_q == IW'(i))) begin
          valid_d[i] = 1'b1;
          vpn_d[i]   = vaddr_q[31:12];
          pfn_d[i]   = lookup_result.phy_addr[31:12];
          dirty_d[i] = lookup_result.dirty;
          cache_d[i] = lookup_result.cache_flag;
        end
      end
      if (!any_match) victim_d = victim_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vaddr_q     <= '0;
      store_q     <= 1'b0;
      asid_q      <= '0;
      last_asid_q <= '0;
      victim_q    <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      for (int i = 0; i < UTLB_ENTRIES; i++) begin
        vpn_q[i]   <= '0;
        pfn_q[i]   <= '0;
        cache_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      vaddr_q     <= vaddr_d;
      store_q     <= store_d;
      asid_q      <= asid_d;
      last_asid_q <= last_asid_d;
      victim_q    <= victim_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      vpn_q       <= vpn_d;
      pfn_q       <= pfn_d;
      cache_q     <= cache_d;
    end
  end
endmodule

// File: tb/tb_utlb_translate.sv
// tb/tb_utlb_translate.sv - scoreboard bench for utlb_translate with a page-table stub and reference model
module tb_utlb_translate;
  import utlb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] req_vaddr = '0;
  logic [7:0]  asid = '0;
  logic        req_ready, resp_valid, resp_uncached;
  logic [31:0] lookup_vaddr, resp_paddr;
  logic [7:0]  lookup_asid;
  logic [1:0]  resp_exc;
  tlb_result_t lookup_result;

  utlb_translate #(.UTLB_ENTRIES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_vaddr(req_vaddr), .req_store(req_store), .asid(asid), .flush(flush),
    .lookup_vaddr(lookup_vaddr), .lookup_asid(lookup_asid), .lookup_result(lookup_result),
    .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_uncached(resp_uncached),
    .resp_exc(resp_exc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Main TLB stub: a small page table of eight vpns.
  logic [19:0] pool_vpn [8];
  logic [19:0] pool_pfn [8];
  logic        pool_miss [8];
  logic        pool_valid [8];
  logic        pool_dirty [8];
  logic [2:0]  pool_cache [8];

  always_comb begin
    lookup_result      = '0;
    lookup_result.miss = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (pool_vpn[j] == lookup_vaddr[31:12]) begin
        lookup_result.miss       = pool_miss[j];
        lookup_result.valid      = pool_valid[j];
        lookup_result.dirty      = pool_dirty[j];
        lookup_result.cache_flag = pool_cache[j];
        lookup_result.phy_addr   = {pool_pfn[j], lookup_vaddr[11:0]};
      end
    end
  end

  function automatic tlb_result_t pt_lookup(input logic [31:0] va);
    tlb_result_t r;
    r = '0;
    r.miss = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (pool_vpn[j] == va[31:12]) begin
        r.miss = pool_miss[j]; r.valid = pool_valid[j]; r.dirty = pool_dirty[j];
        r.cache_flag = pool_cache[j]; r.phy_addr = {pool_pfn[j], va[11:0]};
      end
    end
    return r;
  endfunction

  task automatic set_pool(input int j, input logic [19:0] vpn, input logic [19:0] pfn,
                          input logic m, input logic v, input logic d, input logic [2:0] c);
    pool_vpn[j] = vpn; pool_pfn[j] = pfn; pool_miss[j] = m;
    pool_valid[j] = v; pool_dirty[j] = d; pool_cache[j] = c;
  endtask

  // Reference micro-TLB: four slots filled round-robin.
  typedef struct { bit v; bit [19:0] vpn; bit [19:0] pfn; bit d; bit [2:0] c; } ment_t;
  ment_t mt [4];
  int    vptr = 0;

  typedef struct { int cyc; bit [31:0] paddr; bit unc; bit [1:0] exc; int lat; bit [31:0] va; bit [7:0] asid; } exp_t;
  exp_t sb [$];

  task automatic model_flush();
    for (int i = 0; i < 4; i++) mt[i].v = 1'b0;
  endtask

  task automatic model_reset();
    model_flush();
    vptr = 0;
  endtask

  task automatic predict(input logic [31:0] va, input logic st, output exp_t e);
    int h;
    tlb_result_t lr;
    e = '{default: 0};
    h = -1;
    for (int i = 0; i < 4; i++) if (mt[i].v && mt[i].vpn == va[31:12]) h = i;
    if (va[31:30] == 2'b10) begin
      e.lat = 1; e.paddr = {3'b000, va[28:0]}; e.unc = va[29];
    end else if (h >= 0 && !(st && !mt[h].d)) begin
      e.lat = 1; e.paddr = {mt[h].pfn, va[11:0]}; e.unc = (mt[h].c != 3'd3);
    end else begin
      lr = pt_lookup(va);
      e.lat = 2; e.paddr = lr.phy_addr; e.unc = (lr.cache_flag != 3'd3);
      e.exc = lr.miss ? 2'd1 : !lr.valid ? 2'd2 : (st && !lr.dirty) ? 2'd3 : 2'd0;
      if (!lr.miss && lr.valid) begin
        if (h < 0) begin h = vptr; vptr = (vptr + 1) % 4; end
        mt[h] = '{v: 1'b1, vpn: va[31:12], pfn: lr.phy_addr[31:12], d: lr.dirty, c: lr.cache_flag};
      end
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, expv);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_resp actual_paddr=%h expected=no_response cycle=%0d", resp_paddr, cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_paddr", resp_paddr, e.paddr);
        chk("resp_uncached", {31'd0, resp_uncached}, {31'd0, e.unc});
        chk("resp_exc", {30'd0, resp_exc}, {30'd0, e.exc});
        if (e.lat == 2) begin
          chk("lookup_vaddr", lookup_vaddr, e.va);
          chk("lookup_asid", {24'd0, lookup_asid}, {24'd0, e.asid});
        end
      end
    end
  end

  task automatic send(input logic [31:0] va, input logic st);
    exp_t e;
    int n;
    req_valid = 1'b1; req_vaddr = va; req_store = st;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 10) begin n++; @(negedge clk); end
    if (req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL ready_timeout actual=%b expected=1", req_ready);
    end else begin
      predict(va, st, e);
      e.cyc = cyc + e.lat; e.va = va; e.asid = asid;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = 1'b0;
    while (sb.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic flush_pulse();
    flush = 1'b1; model_flush();
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic set_asid(input logic [7:0] a);
    if (a != asid) model_flush();
    asid = a;
  endtask

  task automatic rand_pool(input int j);
    logic [31:0] t;
    logic [2:0]  jj;
    logic [1:0]  top;
    int          ts;
    t = $urandom(); jj = 3'(j); ts = $urandom_range(0, 2);
    top = (ts == 2) ? 2'b11 : 2'(ts);
    set_pool(j, {top, t[14:0], jj}, t[31:12], ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
  endtask

  initial begin
    logic [31:0] t, va;
    int r, j;
    for (int k = 0; k < 8; k++) set_pool(k, 20'hFFFF0 + 20'(k), '0, 1'b1, 1'b0, 1'b0, 3'd0);
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_paddr", resp_paddr, 32'd0);
    chk("rst_resp_uncached", {31'd0, resp_uncached}, 32'd0);
    chk("rst_resp_exc", {30'd0, resp_exc}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    set_asid(8'h01);

    send(32'h8000_1234, 1'b0); drain();
    send(32'hA000_0010, 1'b0); drain();

    set_pool(0, 20'h00400, 20'h12345, 1'b0, 1'b1, 1'b1, 3'd3);
    set_pool(1, 20'h00401, 20'h11111, 1'b1, 1'b0, 1'b0, 3'd3);
    set_pool(2, 20'h00402, 20'h22222, 1'b0, 1'b0, 1'b1, 3'd3);
    set_pool(3, 20'h00403, 20'h0AAAA, 1'b0, 1'b1, 1'b0, 3'd3);
    set_pool(4, 20'h00404, 20'h0BBBB, 1'b0, 1'b1, 1'b0, 3'd2);
    set_pool(5, 20'h00405, 20'h05555, 1'b0, 1'b1, 1'b1, 3'd3);
    set_pool(6, 20'h00406, 20'h06666, 1'b0, 1'b1, 1'b1, 3'd0);
    set_pool(7, 20'h00407, 20'h07777, 1'b0, 1'b1, 1'b1, 3'd3);

    send(32'h0040_0ABC, 1'b0); drain();
    send(32'h0040_0ABC, 1'b0); drain();
    send(32'h0040_1000, 1'b0); drain();
    send(32'h0040_1004, 1'b0); drain();
    send(32'h0040_2008, 1'b0); drain();
    send(32'h0040_3010, 1'b0); drain();
    send(32'h0040_3014, 1'b1); drain();
    send(32'h0040_4020, 1'b0); drain();
    send(32'h0040_4024, 1'b1); drain();

    // Five distinct refills: the fifth takes the first slot again.
    flush_pulse();
    foreach (pool_vpn[k]) if (k == 0 || k == 3 || k == 4 || k == 5 || k == 6) begin
      send({pool_vpn[k], 12'h100}, 1'b0); drain();
    end
    send({pool_vpn[0], 12'h104}, 1'b0); drain();

    // Flush in the same cycle as a refill.
    flush_pulse();
    send({pool_vpn[7], 12'h010}, 1'b0); drain();
    send({pool_vpn[0], 12'h020}, 1'b0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; model_flush();
    @(posedge clk); #1;
    flush = 1'b0;
    drain();
    send({pool_vpn[7], 12'h030}, 1'b0); drain();
    send({pool_vpn[0], 12'h040}, 1'b0); drain();

    set_asid(8'h02);
    send({pool_vpn[7], 12'h050}, 1'b0); drain();

    // Back-to-back hits with req_valid held high.
    flush_pulse();
    send({pool_vpn[0], 12'h0}, 1'b0); drain();
    send({pool_vpn[3], 12'h0}, 1'b0); drain();
    send({pool_vpn[5], 12'h0}, 1'b0); drain();
    send({pool_vpn[6], 12'h0}, 1'b0); drain();
    for (int k = 0; k < 8; k++) begin
      j = (k % 4 == 0) ? 0 : (k % 4 == 1) ? 3 : (k % 4 == 2) ? 5 : 6;
      send({pool_vpn[j], 12'(k * 16)}, 1'b0);
    end
    drain();

    // Reset during LOOKUP: no response, no refill.
    flush_pulse();
    req_valid = 1'b1; req_vaddr = {pool_vpn[7], 12'h321}; req_store = 1'b0;
    @(negedge clk);
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    send({pool_vpn[7], 12'h321}, 1'b0); drain();

    for (int k = 0; k < 8; k++) rand_pool(k);
    flush_pulse();
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        drain(); flush_pulse();
      end else if (r < 7) begin
        drain(); set_asid(8'($urandom_range(0, 3)));
      end else if (r < 9) begin
        drain(); rand_pool($urandom_range(0, 7)); flush_pulse();
      end else begin
        t = $urandom();
        if (r < 24) va = {2'b10, t[29:0]};
        else begin
          j = $urandom_range(0, 7);
          va = {pool_vpn[j], t[11:0]};
        end
        send(va, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) drain();
      end
    end
    drain();
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
